// File: rtl/if_prefetch_pkg.sv
// Shared types for the instruction-fetch prefetch unit: FSM state encoding,
// fetch granularity and the default-width fetch-entry record.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_INST_W = 32;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_inst_queue.sv
// Synchronous DEPTH-entry FIFO of fetch entries with single-cycle flush.
// The head entry is read straight from the storage registers.
module inst_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch unit: single-outstanding memory requests feeding
// a DEPTH-entry queue toward IF/ID, with redirect flush and response drop.
module if_prefetch
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_ready,
    output logic              if_stall
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic [CNT_W-1:0]  count;
    logic              has_room;
    logic              push;
    logic              pop;
    logic              grant;
    entry_t            head;
    entry_t            push_entry;
    logic [1:0]        unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];

    assign has_room = count < CNT_W'(DEPTH);
    assign mem_req  = (state == IDLE) && has_room && !redirect_valid && !rst;
    assign mem_addr = fetch_pc;
    assign grant    = mem_req && mem_gnt;

    assign id_valid = (count != '0) && !rst;
    assign id_inst  = id_valid ? head.inst : '0;
    assign id_pc    = id_valid ? head.pc   : '0;
    assign if_stall = !id_valid;

    // A redirect flushes the queue, so a pop in that cycle is meaningless.
    assign pop = id_valid && id_ready && !redirect_valid;

    assign push_entry.pc   = req_pc;
    assign push_entry.inst = mem_rdata;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                    push      = !redirect_valid;
                end else if (redirect_valid) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (push) begin
                fetch_pc <= fetch_pc + ADDR_W'(INST_BYTES);
            end
            if (grant) begin
                req_pc <= fetch_pc;
            end
        end
    end

    inst_queue #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head_data(head),
        .count    (count)
    );

endmodule
